// File: rtl/qbus_slave.sv
// Q-bus/MPI responder: decodes an address window and maps DATI/DATO/DATOB/DATIO cycles onto a local register port.
// Optional macro QSL_RMW_EN: service further data phases under one SYNC (read-modify-write).
module qbus_slave #(
    parameter logic [15:0] BASE     = 16'o176540,
    parameter int unsigned AW       = 2,
    parameter int unsigned IOPAGE   = 1,
    parameter int unsigned RPLY_DLY = 1
) (
    input  logic          MCLK,
    input  logic          RST,
    input  logic          nSYNC,
    input  logic          nDIN,
    input  logic          nDOUT,
    input  logic          nWTBT,
    input  logic          nBS,
    input  logic          nINIT,
    input  logic [15:0]   AD_IN,
    output logic [15:0]   AD_OUT,
    output logic          AD_OE,
    output logic          nRPLY,
    output logic [AW-1:0] lc_adr,
    output logic [15:0]   lc_dat_o,
    input  logic [15:0]   lc_dat_i,
    output logic          lc_we,
    output logic [1:0]    lc_sel,
    output logic          lc_stb,
    input  logic          lc_ack
);

    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RSTB,
        S_RDLY,
        S_WSTB,
        S_RPLY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_sync_s1, r_sync_s2;
    logic          r_din_s1,  r_din_s2;
    logic          r_dout_s1, r_dout_s2;
    logic          r_init_s1, r_init_s2;
    logic [15:0]   r_adr_hold;
    logic          r_bs_hold;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_ad_out;
    logic [15:0]   r_dat_o;
    logic          r_ad_oe;
    logic          r_rply_n;
    logic          r_we;
    logic          r_stb;
    logic [1:0]    r_sel;
    logic          w_sel;
    logic          w_abort;

    // Two-flop synchronizers for the asynchronous bus strobes
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_sync_s1 <= 1'b1;
            r_sync_s2 <= 1'b1;
            r_din_s1  <= 1'b1;
            r_din_s2  <= 1'b1;
            r_dout_s1 <= 1'b1;
            r_dout_s2 <= 1'b1;
            r_init_s1 <= 1'b1;
            r_init_s2 <= 1'b1;
        end else begin
            r_sync_s1 <= nSYNC;
            r_sync_s2 <= r_sync_s1;
            r_din_s1  <= nDIN;
            r_din_s2  <= r_din_s1;
            r_dout_s1 <= nDOUT;
            r_dout_s2 <= r_dout_s1;
            r_init_s1 <= nINIT;
            r_init_s2 <= r_init_s1;
        end
    end

    // Address tracks the bus until SYNC is first seen, then freezes for the whole cycle
    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_adr_hold <= '0;
            r_bs_hold  <= 1'b1;
        end else if (r_sync_s1) begin
            r_adr_hold <= AD_IN;
            r_bs_hold  <= nBS;
        end
    end

    assign w_sel   = (r_adr_hold[15:AW+1] == BASE[15:AW+1]) && ((IOPAGE == 0) || !r_bs_hold);
    assign w_abort = !r_init_s2 || (r_sync_s2 && (r_state != S_IDLE));

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ad_out <= '0;
            r_dat_o  <= '0;
            r_ad_oe  <= 1'b0;
            r_rply_n <= 1'b1;
            r_we     <= 1'b0;
            r_stb    <= 1'b0;
            r_sel    <= 2'b00;
        end else if (w_abort) begin
            // SYNC dropped or INIT: quietly release the bus, any late lc_ack is ignored
            r_state  <= S_IDLE;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_rply_n <= 1'b1;
            r_ad_oe  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_sync_s2) r_state <= S_ADDR;
                end
                S_ADDR: begin
                    if (!w_sel) begin
                        r_state <= S_DONE;
                    end else if (!r_din_s2 && r_dout_s2) begin
                        r_stb   <= 1'b1;
                        r_we    <= 1'b0;
                        r_sel   <= 2'b11;
                        r_state <= S_RSTB;
                    end else if (!r_dout_s2 && r_din_s2) begin
                        r_dat_o <= AD_IN;
                        r_sel   <= nWTBT ? 2'b11 : (r_adr_hold[0] ? 2'b10 : 2'b01);
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_state <= S_WSTB;
                    end else if (!r_din_s2 && !r_dout_s2) begin
                        r_state <= S_DONE;
                    end
                end
                S_RSTB: begin
                    if (lc_ack) begin
                        r_ad_out <= lc_dat_i;
                        r_ad_oe  <= 1'b1;
                        r_stb    <= 1'b0;
                        r_cnt    <= CW'(RPLY_DLY);
                        r_state  <= S_RDLY;
                    end
                end
                S_RDLY: begin
                    // Data setup time on the bus before RPLY
                    if (r_cnt == '0) begin
                        r_rply_n <= 1'b0;
                        r_state  <= S_RPLY;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_WSTB: begin
                    if (lc_ack) begin
                        r_stb    <= 1'b0;
                        r_we     <= 1'b0;
                        r_rply_n <= 1'b0;
                        r_state  <= S_RPLY;
                    end
                end
                S_RPLY: begin
                    if (r_din_s2 && r_dout_s2) begin
                        r_rply_n <= 1'b1;
                        r_ad_oe  <= 1'b0;
`ifdef QSL_RMW_EN
                        r_state  <= S_ADDR;
`else
                        r_state  <= S_DONE;
`endif
                    end
                end
                S_DONE: begin
                    if (r_sync_s2) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign AD_OUT   = r_ad_out;
    assign AD_OE    = r_ad_oe;
    assign nRPLY    = r_rply_n;
    assign lc_adr   = r_adr_hold[AW:1];
    assign lc_dat_o = r_dat_o;
    assign lc_we    = r_we;
    assign lc_sel   = r_sel;
    assign lc_stb   = r_stb;

endmodule

// File: tb/tb_qbus_slave.sv
// Bench for qbus_slave: directed bus cycles checked against a window/lane model and a per-cycle compare process.
module tb_qbus_slave;

    localparam logic [15:0] BASE     = 16'o176540;
    localparam int unsigned AW       = 2;
    localparam int unsigned RPLY_DLY = 1;
`ifdef QSL_RMW_EN
    localparam logic RMW = 1'b1;
`else
    localparam logic RMW = 1'b0;
`endif

    localparam int M_OFF   = 0;
    localparam int M_QUIET = 1;
    localparam int M_ACT   = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic        bs;
        logic        wr;
        logic        byt;
        logic [15:0] data;
    } vec_t;

    logic          MCLK = 1'b0;
    logic          RST = 1'b1;
    logic          nSYNC = 1'b1;
    logic          nDIN = 1'b1;
    logic          nDOUT = 1'b1;
    logic          nWTBT = 1'b1;
    logic          nBS = 1'b1;
    logic          nINIT = 1'b1;
    logic [15:0]   AD_IN = '0;
    logic [15:0]   lc_dat_i = '0;
    logic          lc_ack = 1'b0;
    logic [15:0]   AD_OUT;
    logic          AD_OE;
    logic          nRPLY;
    logic [AW-1:0] lc_adr;
    logic [15:0]   lc_dat_o;
    logic          lc_we;
    logic [1:0]    lc_sel;
    logic          lc_stb;

    qbus_slave #(
        .BASE(BASE), .AW(AW), .IOPAGE(1), .RPLY_DLY(RPLY_DLY)
    ) dut (
        .MCLK(MCLK), .RST(RST), .nSYNC(nSYNC), .nDIN(nDIN), .nDOUT(nDOUT),
        .nWTBT(nWTBT), .nBS(nBS), .nINIT(nINIT), .AD_IN(AD_IN),
        .AD_OUT(AD_OUT), .AD_OE(AD_OE), .nRPLY(nRPLY),
        .lc_adr(lc_adr), .lc_dat_o(lc_dat_o), .lc_dat_i(lc_dat_i),
        .lc_we(lc_we), .lc_sel(lc_sel), .lc_stb(lc_stb), .lc_ack(lc_ack)
    );

    always #5 MCLK = ~MCLK;

    int          n_checks = 0;
    int          n_fail = 0;
    int          exp_mode = M_OFF;
    logic [1:0]  exp_adr = '0;
    logic [1:0]  exp_lanes = '0;
    logic        exp_we = 1'b0;
    logic [15:0] exp_wdat = '0;
    logic [15:0] exp_rdat = '0;
    logic        ack_en = 1'b1;
    logic        stb_seen = 1'b0;
    logic [1:0]  cap_adr = '0;
    logic [1:0]  cap_sel = '0;
    logic        cap_we = 1'b0;
    logic [15:0] cap_dat = '0;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o, want %0o", name, act, exp);
        end
    endtask

    // Model: the window is BASE..BASE+7 inside the I/O page; word index = byte offset / 2;
    // a byte write to an odd address hits the high lane.
    function automatic logic m_hit(input logic [15:0] a, input logic bs);
        return (a >= BASE) && (a < BASE + 16'd8) && !bs;
    endfunction

    function automatic logic [1:0] m_adr(input logic [15:0] a);
        return 2'((a - BASE) / 16'd2);
    endfunction

    function automatic logic [1:0] m_lanes(input logic byt, input logic [15:0] a);
        if (!byt) return 2'b11;
        return (a % 16'd2 == 16'd1) ? 2'b10 : 2'b01;
    endfunction

    // Local register port: acknowledge one cycle after the strobe, record the first strobe seen
    always @(negedge MCLK) begin
        if (lc_stb && !stb_seen) begin
            stb_seen = 1'b1;
            cap_adr  = lc_adr;
            cap_sel  = lc_sel;
            cap_we   = lc_we;
            cap_dat  = lc_dat_o;
        end
        lc_ack = lc_stb && ack_en && !lc_ack;
    end

    // Per-cycle compare against the model expectations
    always @(negedge MCLK) begin
        if (exp_mode == M_QUIET) begin
            check("idle_stb", lc_stb, 1'b0);
            check("idle_rply", nRPLY, 1'b1);
            check("idle_oe", AD_OE, 1'b0);
        end else if (exp_mode == M_ACT) begin
            if (lc_stb) begin
                check("stb_adr", lc_adr, exp_adr);
                check("stb_sel", lc_sel, exp_lanes);
                check("stb_we", lc_we, exp_we);
                if (lc_we) check("stb_wdat", lc_dat_o, exp_wdat);
            end
            if (AD_OE) check("ad_out", AD_OUT, exp_rdat);
            if (!nRPLY && !exp_we) check("rply_with_oe", AD_OE, 1'b1);
        end
    end

    task automatic bus_addr(input logic [15:0] a, input logic bs, input logic wr, input int mode);
        AD_IN    = a;
        nBS      = bs;
        nWTBT    = !wr;
        exp_adr  = m_adr(a);
        exp_mode = mode;
        nSYNC    = 1'b0;
        repeat (2) @(negedge MCLK);
    endtask

    task automatic bus_data(input logic wr, input logic byt, input logic [15:0] wd,
                            output logic got, output int lat, output logic [15:0] dq);
        int   rel;
        logic rel_done;
        stb_seen = 1'b0;
        nWTBT    = !byt;
        got = 1'b0;
        lat = 0;
        dq  = '0;
        if (wr) begin
            AD_IN = wd;
            nDOUT = 1'b0;
        end else begin
            nDIN = 1'b0;
        end
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge MCLK);
            if (!nRPLY) begin
                got = 1'b1;
                lat = k - 1;
                dq  = AD_OE ? AD_OUT : 16'hFFFF;
            end
        end
        nDIN  = 1'b1;
        nDOUT = 1'b1;
        nWTBT = 1'b1;
        rel = 0;
        rel_done = 1'b0;
        for (int k = 1; k <= 8 && !rel_done; k++) begin
            @(negedge MCLK);
            if (nRPLY && !AD_OE) begin
                rel_done = 1'b1;
                rel = k;
            end
        end
        if (got) check("release_within_3", (rel >= 1) && (rel <= 3), 1'b1);
    endtask

    task automatic end_cycle();
        nSYNC = 1'b1;
        nBS   = 1'b1;
        AD_IN = '0;
        repeat (3) @(negedge MCLK);
        exp_mode = M_QUIET;
    endtask

    task automatic run_vec(input vec_t v);
        logic        hit;
        logic        got;
        int          lat;
        logic [15:0] dq;
        hit       = m_hit(v.addr, v.bs);
        exp_lanes = m_lanes(v.byt, v.addr);
        exp_we    = v.wr;
        exp_wdat  = v.data;
        exp_rdat  = v.data;
        lc_dat_i  = v.data;
        bus_addr(v.addr, v.bs, v.wr, hit ? M_ACT : M_QUIET);
        bus_data(v.wr, v.byt, v.data, got, lat, dq);
        check("rply_present", got, hit);
        check("stb_present", stb_seen, hit);
        if (got && !v.wr) begin
            check("rd_latency", lat, 4 + RPLY_DLY);
            check("rd_data", dq, v.data);
        end
        if (got && v.wr) check("wr_latency_max4", lat <= 4, 1'b1);
        end_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        got;
        logic        flag;
        logic        oe_seen;
        logic        late_bad;
        int          lat;
        int          drop;
        logic [15:0] dq;

        vecs[0] = '{16'o176542, 1'b0, 1'b0, 1'b0, 16'o123456};
        vecs[1] = '{16'o176545, 1'b0, 1'b1, 1'b1, 16'o177400};
        vecs[2] = '{16'o176546, 1'b0, 1'b1, 1'b0, 16'o052525};
        vecs[3] = '{16'o176544, 1'b0, 1'b1, 1'b1, 16'o000377};
        vecs[4] = '{16'o176540, 1'b0, 1'b0, 1'b0, 16'o000001};
        vecs[5] = '{16'o176550, 1'b0, 1'b0, 1'b0, 16'o000000};
        vecs[6] = '{16'o176540, 1'b1, 1'b0, 1'b0, 16'o000000};
        vecs[7] = '{16'o176536, 1'b0, 1'b0, 1'b0, 16'o000000};

        repeat (3) @(negedge MCLK);
        check("rst_rply", nRPLY, 1'b1);
        check("rst_oe", AD_OE, 1'b0);
        check("rst_adout", AD_OUT, 16'o0);
        check("rst_stb", lc_stb, 1'b0);
        check("rst_we", lc_we, 1'b0);
        check("rst_sel", lc_sel, 2'b00);
        check("rst_adr", lc_adr, 2'd0);
        check("rst_dat_o", lc_dat_o, 16'o0);
        RST = 1'b0;
        exp_mode = M_QUIET;
        repeat (3) @(negedge MCLK);

        // Read BASE+2 and byte write to BASE+5, pinned with literal values
        run_vec(vecs[0]);
        check("v0_lc_adr", cap_adr, 2'd1);
        check("v0_lc_sel", cap_sel, 2'b11);
        check("v0_lc_we", cap_we, 1'b0);
        run_vec(vecs[1]);
        check("v1_lc_adr", cap_adr, 2'd2);
        check("v1_lc_sel", cap_sel, 2'b10);
        check("v1_lc_we", cap_we, 1'b1);
        check("v1_lc_dat_o", cap_dat, 16'o177400);
        for (int i = 2; i < 8; i++) run_vec(vecs[i]);

        // SYNC dropped while the strobe waits for an ack that never comes
        exp_lanes = 2'b11;
        exp_we    = 1'b0;
        exp_rdat  = 16'o111111;
        lc_dat_i  = 16'o111111;
        ack_en    = 1'b0;
        bus_addr(BASE, 1'b0, 1'b0, M_ACT);
        nDIN = 1'b0;
        got  = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge MCLK);
            if (lc_stb) got = 1'b1;
        end
        check("abort_stb_up", got, 1'b1);
        nSYNC = 1'b1;
        flag  = 1'b0;
        drop  = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge MCLK);
            if (!nRPLY || AD_OE) flag = 1'b1;
            if (!lc_stb && drop == 0) drop = k;
        end
        check("abort_stb_drop", (drop >= 1) && (drop <= 3), 1'b1);
        check("abort_no_rply", flag, 1'b0);
        nDIN   = 1'b1;
        nBS    = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(negedge MCLK);
        exp_mode = M_QUIET;
        run_vec(vecs[4]);

        // Read then write under one SYNC
        exp_lanes = 2'b11;
        exp_we    = 1'b0;
        exp_rdat  = 16'o000007;
        lc_dat_i  = 16'o000007;
        bus_addr(BASE, 1'b0, 1'b0, M_ACT);
        bus_data(1'b0, 1'b0, 16'o0, got, lat, dq);
        check("rmw_rd_rply", got, 1'b1);
        check("rmw_rd_data", dq, 16'o000007);
        exp_we   = 1'b1;
        exp_wdat = 16'o000010;
        exp_mode = RMW ? M_ACT : M_QUIET;
        bus_data(1'b1, 1'b0, 16'o000010, got, lat, dq);
        check("rmw_wr_rply", got, RMW);
        check("rmw_wr_stb", stb_seen, RMW);
        end_cycle();

        // INIT asserted so that it lands while read data is set up but before RPLY
        exp_mode  = M_OFF;
        exp_we    = 1'b0;
        lc_dat_i  = 16'o002222;
        bus_addr(BASE + 16'd2, 1'b0, 1'b0, M_OFF);
        nDIN = 1'b1;
        nDIN = 1'b0;
        repeat (2) @(negedge MCLK);
        nINIT    = 1'b0;
        oe_seen  = 1'b0;
        flag     = 1'b0;
        late_bad = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge MCLK);
            if (AD_OE) oe_seen = 1'b1;
            if (!nRPLY) flag = 1'b1;
            if (j >= 4 && (lc_stb || AD_OE)) late_bad = 1'b1;
        end
        check("init_oe_reached", oe_seen, 1'b1);
        check("init_no_rply", flag, 1'b0);
        check("init_held_idle", late_bad, 1'b0);
        nDIN  = 1'b1;
        nSYNC = 1'b1;
        nBS   = 1'b1;
        repeat (3) @(negedge MCLK);
        nINIT = 1'b1;
        repeat (4) @(negedge MCLK);
        exp_mode = M_QUIET;
        run_vec(vecs[0]);

        // RST while replying to a read
        exp_lanes = 2'b11;
        exp_we    = 1'b0;
        exp_rdat  = 16'o004321;
        lc_dat_i  = 16'o004321;
        bus_addr(BASE + 16'd4, 1'b0, 1'b0, M_ACT);
        nDIN = 1'b0;
        got  = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge MCLK);
            if (!nRPLY) got = 1'b1;
        end
        check("rst_pre_rply", got, 1'b1);
        exp_mode = M_OFF;
        #2 RST = 1'b1;
        #1;
        check("rst_mid_rply", nRPLY, 1'b1);
        check("rst_mid_oe", AD_OE, 1'b0);
        check("rst_mid_adout", AD_OUT, 16'o0);
        check("rst_mid_stb", lc_stb, 1'b0);
        check("rst_mid_adr", lc_adr, 2'd0);
        nDIN  = 1'b1;
        nSYNC = 1'b1;
        nBS   = 1'b1;
        repeat (3) @(negedge MCLK);
        RST = 1'b0;
        repeat (3) @(negedge MCLK);
        exp_mode = M_QUIET;
        run_vec(vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
